wb_unit: RTL

WB_UNIT -- requirements
Module: wb_unit

---
 rtl/wb_unit_pkg.sv | 34 +++
 rtl/wb_scoreboard.sv | 50 +++++
 rtl/wb_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/wb_unit_pkg.sv
// Shared definitions for the write-back unit: register-file widths,
// the hard-wired zero register, the zero word, and the arbitration source type.
package wb_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG  = '0;
  localparam reg_data_t ZERO_WORD = '0;

  // One buffered long-latency result
  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    reg_data_t data;
  } wb_entry_t;

  // Which source loads the output register this cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_A    = 2'd1,
    SRC_BUF  = 2'd2
  } wb_src_e;

  // Writes to the zero register are swallowed
  function automatic logic is_zero_reg(input reg_addr_t addr);
    return addr == ZERO_REG;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Busy scoreboard: one bit per architectural register, marking registers
// still waiting for a long-latency result. A set and a clear of the same
// bit in one cycle leave the bit set (a fresh issue overrides the old result).
module wb_scoreboard
  import wb_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  input  reg_addr_t rd_addr,
  output logic      rs1_busy,
  output logic      rs2_busy,
  output logic      rd_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Per-bit next state; the zero register can never be busy
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
    if (gi == 0) begin : g_zero
      assign busy_d[gi] = 1'b0;
    end else begin : g_live
      logic set_hit;
      logic clr_hit;
      assign set_hit    = set_en && (set_addr == reg_addr_t'(gi));
      assign clr_hit    = clr_en && (clr_addr == reg_addr_t'(gi));
      assign busy_d[gi] = set_hit | (busy_q[gi] & ~clr_hit);
    end
  end

  // Busy vector register, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];
  assign rd_busy  = busy_q[rd_addr];

endmodule

// File: rtl/wb_unit.sv
// Write-back unit: merges single-cycle (A) and long-latency (B) results into
// one registered register-file write port. B results wait in a one-entry
// buffer and normally yield to A. Defining WB_STARVE_GUARD_EN adds a starve
// counter that forces the buffered B result out after STARVE_MAX lost cycles.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      a_valid,
  output logic      a_ready,
  input  reg_addr_t a_rd,
  input  reg_data_t a_data,
  input  logic      b_valid,
  output logic      b_ready,
  input  reg_addr_t b_rd,
  input  reg_data_t b_data,
  input  logic      iss_en,
  input  reg_addr_t iss_rd,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      rs1_busy,
  output logic      rs2_busy,
  output logic      rd_busy,
  output logic      wr_en,
  output reg_addr_t wr_addr,
  output reg_data_t wr_data
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("wb_unit: STARVE_MAX must be in 1..15");
  end

  wb_entry_t buf_q;
  wb_entry_t buf_d;
  logic      wr_en_q;
  logic      wr_en_d;
  reg_addr_t wr_addr_q;
  reg_addr_t wr_addr_d;
  reg_data_t wr_data_q;
  reg_data_t wr_data_d;
  wb_src_e   src;
  logic      forced_b;
  logic      buf_drain;

`ifdef WB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  logic [3:0] starve_q;
  logic [3:0] starve_d;

  // The buffer has lost STARVE_MAX times in a row: it owns this cycle
  assign forced_b = buf_q.valid && (starve_q == STARVE_LIMIT);

  // Count consecutive lost cycles of the current buffered entry
  always_comb begin
    starve_d = starve_q;
    if (buf_drain) begin
      starve_d = '0;
    end else if (buf_q.valid) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Starve counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Without the guard A always beats the buffer
  assign forced_b = 1'b0;
`endif

  assign a_ready   = ~forced_b;
  assign buf_drain = (src == SRC_BUF);
  assign b_ready   = ~buf_q.valid | buf_drain;

  // Arbitration: forced buffer, then A, then buffer
  always_comb begin
    src = SRC_NONE;
    if (forced_b) begin
      src = SRC_BUF;
    end else if (a_valid) begin
      src = SRC_A;
    end else if (buf_q.valid) begin
      src = SRC_BUF;
    end
  end

  // Buffer next state: drain and refill can happen in the same cycle
  always_comb begin
    buf_d = buf_q;
    if (buf_drain) begin
      buf_d.valid = 1'b0;
    end
    if (b_valid && b_ready) begin
      buf_d = '{valid: 1'b1, rd: b_rd, data: b_data};
    end
  end

  // Output register next state; address/data hold when nothing wins
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (src)
      SRC_A: begin
        wr_en_d   = ~is_zero_reg(a_rd);
        wr_addr_d = a_rd;
        wr_data_d = a_data;
      end
      SRC_BUF: begin
        wr_en_d   = ~is_zero_reg(buf_q.rd);
        wr_addr_d = buf_q.rd;
        wr_data_d = buf_q.data;
      end
      default: ;
    endcase
  end

  // Buffer and write-port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q     <= '{valid: 1'b0, rd: ZERO_REG, data: ZERO_WORD};
      wr_en_q   <= 1'b0;
      wr_addr_q <= ZERO_REG;
      wr_data_q <= ZERO_WORD;
    end else begin
      buf_q     <= buf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  // A B result leaving the buffer frees its destination at the same edge
  // that loads it into the output register
  wb_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (iss_en),
    .set_addr (iss_rd),
    .clr_en   (buf_drain),
    .clr_addr (buf_q.rd),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rd_addr  (iss_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

endmodule
